xadc_uart_sequencer: RTL and testbench

- Takes 12-bit XADC samples through a valid/ready handshake and transmits each one over UART 8N1 as uppercase ASCII hex followed by a terminator.
- Owns the baud-rate tick generation, restarting it at every byte so bit timing stays aligned.
- Sits between the XADC sampling logic and the board UART TX pin. It is the single sequencer of the serial line.

---
 rtl/xadc_uart_pkg.sv | 27 ++
 rtl/baud_tick_gen.sv | 16 +
 rtl/xadc_uart_sequencer.sv | 90 +++++++++
 tb/tb_xadc_uart_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/xadc_uart_pkg.sv
// xadc_uart_pkg: shared FSM states, ASCII constants and frame byte helpers for xadc_uart_sequencer.
// Build option XADC_UART_CRLF_EN selects a CR LF terminator (NBYTES=5) instead of a space (NBYTES=4).
package xadc_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
`ifdef XADC_UART_CRLF_EN
  localparam int NBYTES = 5;
  localparam logic [7:0] TERM0 = ASCII_CR;
  localparam logic [7:0] TERM1 = ASCII_LF;
`else
  localparam int NBYTES = 4;
  localparam logic [7:0] TERM0 = ASCII_SP;
  localparam logic [7:0] TERM1 = ASCII_SP;
`endif
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  // Byte i of the frame for sample d: three hex digits, most significant first, then the terminator.
  function automatic logic [7:0] frame_byte(input logic [11:0] d, input logic [2:0] i);
    return i == 3'd0 ? hex_ascii(d[11:8]) :
           i == 3'd1 ? hex_ascii(d[7:4]) :
           i == 3'd2 ? hex_ascii(d[3:0]) :
           i == 3'd3 ? TERM0 : TERM1;
  endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: modulo-BAUD_DIV bit timer with synchronous restart.
// Ports: clk, rst_n (async active-low), restart (zero the count), tick (high on the last cycle of each bit period).
module baud_tick_gen #(
  parameter int unsigned BAUD_DIV = 10417
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  logic [31:0] cnt;
  assign tick = cnt == 32'(BAUD_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 32'd1;
endmodule

// File: rtl/xadc_uart_sequencer.sv
// xadc_uart_sequencer: sends each accepted 12-bit XADC sample over UART 8N1 as 3 uppercase hex chars plus a terminator.
// Ports: clk, rst_n (async active-low), sample_data/sample_valid/sample_ready (input handshake),
//        tx (serial out, idle high), busy (frame in progress), frame_done (pulse in the last stop-bit cycle).
// Build option XADC_UART_CRLF_EN: terminator CR LF instead of a single space.
module xadc_uart_sequencer
  import xadc_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 10417,
  parameter int SAMPLE_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                tx,
  output logic                busy,
  output logic                frame_done
);
  state_t state, state_n;
  logic [11:0] data, data_n;
  logic [2:0] byte_idx, byte_n, bit_idx, bit_n;
  logic [7:0] cur_byte;
  logic rdy, tick, restart, accept, last_stop, tx_n;

  baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .restart(restart),
    .tick(tick)
  );

  // Ready is also raised in the final stop-bit cycle so a waiting sample starts with no idle gap.
  assign last_stop = state == STOP && tick && byte_idx == 3'(NBYTES - 1);
  assign frame_done = last_stop;
  assign sample_ready = rdy && (state == IDLE || last_stop);
  assign accept = sample_valid && sample_ready;
  assign busy = state != IDLE;

  always_comb begin
    state_n = state;
    data_n = data;
    byte_n = byte_idx;
    bit_n = bit_idx;
    restart = 1'b0;
    if (accept) begin
      state_n = START;
      data_n = sample_data;
      byte_n = 3'd0;
      restart = 1'b1;
    end else if (tick) begin
      case (state)
        IDLE: ;
        START: begin
          state_n = DATA;
          bit_n = 3'd0;
        end
        DATA: begin
          state_n = bit_idx == 3'd7 ? STOP : DATA;
          bit_n = bit_idx + 3'd1;
        end
        STOP: begin
          state_n = last_stop ? IDLE : START;
          byte_n = byte_idx + 3'd1;
          restart = 1'b1;
        end
      endcase
    end
    // tx is registered from the next state so the pin never glitches.
    cur_byte = frame_byte(data_n, byte_n);
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? cur_byte[bit_n] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      data <= '0;
      byte_idx <= '0;
      bit_idx <= '0;
      tx <= 1'b1;
      rdy <= 1'b0;
    end else begin
      state <= state_n;
      data <= data_n;
      byte_idx <= byte_n;
      bit_idx <= bit_n;
      tx <= tx_n;
      rdy <= 1'b1;
    end
endmodule

// File: tb/tb_xadc_uart_sequencer.sv
// tb_xadc_uart_sequencer: randomized self-checking bench against a frame-level UART model.
module tb_xadc_uart_sequencer;
  localparam int BD = 4;
`ifdef XADC_UART_CRLF_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FLEN = NB * 10 * BD;
  logic clk = 1'b0, rst_n = 1'b0, sample_valid = 1'b0;
  logic [11:0] sample_data = '0;
  logic sample_ready, tx, busy, frame_done;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  xadc_uart_sequencer #(.BAUD_DIV(BD), .SAMPLE_W(12)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .tx(tx),
    .busy(busy),
    .frame_done(frame_done)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic int exp_byte(int d, int i);
    int n;
    if (i < 3) begin
      n = (d >> (4 * (2 - i))) & 15;
      return n < 10 ? 48 + n : 55 + n;
    end
    if (NB == 5) return i == 3 ? 13 : 10;
    return 32;
  endfunction

  function automatic logic exp_tx(int d, int k);
    int b = k / BD;
    int pos = b % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return ((exp_byte(d, b / 10) >> (pos - 1)) & 1) != 0;
  endfunction

  task automatic accept(input logic [11:0] d);
    int w = 0;
    while (sample_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready: sample_ready=%b required 1", sample_ready);
    end
    sample_valid = 1'b1;
    sample_data = d;
    @(negedge clk);
  endtask

  // Called at the first negedge after the accept edge; walks the whole frame cycle by cycle.
  task automatic check_frame(input logic [11:0] d, input logic hold, input logic [11:0] nd, input int pulse_at);
    int errs = 0, first_k = -1, fd_at = -1;
    logic first_tx = 1'b0;
    int got[5];
    for (int i = 0; i < 5; i++) got[i] = 0;
    for (int k = 0; k < FLEN; k++) begin
      if (tx !== exp_tx(d, k) || busy !== 1'b1 || sample_ready !== (k == FLEN - 1)) begin
        if (errs == 0) begin
          first_k = k;
          first_tx = tx;
        end
        errs++;
      end
      if (frame_done === 1'b1) fd_at = fd_at < 0 ? k : -2;
      if (k % BD == BD / 2 && (k / BD) % 10 >= 1 && (k / BD) % 10 <= 8)
        got[k / BD / 10] |= int'(tx === 1'b1) << ((k / BD) % 10 - 1);
      if (k == 0) begin
        sample_valid = hold;
        if (hold) sample_data = nd;
      end
      if (k == pulse_at) begin
        sample_valid = 1'b1;
        sample_data = 12'h123;
      end
      if (k == pulse_at + 1) sample_valid = 1'b0;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL wave_%03h: %0d bad cycles, first at k=%0d tx=%b required %b", d, errs, first_k, first_tx, exp_tx(d, first_k));
    end
    total++;
    if (fd_at != FLEN - 1) begin
      bad++;
      $display("FAIL frame_done_%03h: pulse at cycle %0d required %0d", d, fd_at, FLEN - 1);
    end
    for (int i = 0; i < NB; i++) begin
      total++;
      if (got[i] != exp_byte(d, i)) begin
        bad++;
        $display("FAIL byte%0d_%03h: got 0x%02h required 0x%02h", i, d, got[i], exp_byte(d, i));
      end
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int errs = 0;
    for (int k = 0; k < cycles; k++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || sample_ready !== 1'b1 || frame_done !== 1'b0) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s: %0d idle cycles wrong (tx=%b busy=%b ready=%b) required 1/0/1", name, errs, tx, busy, sample_ready);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({tx, busy, sample_ready, frame_done} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_state: tx/busy/ready/done=%b required 1000", {tx, busy, sample_ready, frame_done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("reset_idle", 100);
  endtask

  task automatic test_frame_content;
    accept(12'hABC);
    check_frame(12'hABC, 1'b0, 12'h000, -10);
    check_quiet("after_abc", 10);
  endtask

  task automatic test_hex_digits;
    accept(12'h09F);
    check_frame(12'h09F, 1'b0, 12'h000, -10);
  endtask

  task automatic test_back_to_back;
    accept(12'h000);
    check_frame(12'h000, 1'b1, 12'hFFF, -10);
    check_frame(12'hFFF, 1'b0, 12'h000, -10);
    check_quiet("after_b2b", 10);
  endtask

  task automatic test_ignored_valid;
    accept(12'h7E4);
    check_frame(12'h7E4, 1'b0, 12'h000, 57);
    check_quiet("no_extra_frame", 20 * BD);
  endtask

  task automatic test_reset_mid_frame;
    accept(12'h3C1);
    sample_valid = 1'b0;
    repeat (89) @(negedge clk);
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: tx=%b busy=%b required 0/1", tx, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({tx, busy, sample_ready, frame_done} !== 4'b1000) begin
      bad++;
      $display("FAIL async_reset: tx/busy/ready/done=%b required 1000", {tx, busy, sample_ready, frame_done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("post_reset", 5);
    accept(12'h5A7);
    check_frame(12'h5A7, 1'b0, 12'h000, -10);
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) begin
      logic [11:0] d = 12'($urandom_range(0, 4095));
      int p = n[0] ? $urandom_range(2, FLEN - 5) : -10;
      accept(d);
      check_frame(d, 1'b0, 12'h000, p);
    end
  endtask

  initial begin
    test_reset;
    test_frame_content;
    test_hex_digits;
    test_back_to_back;
    test_ignored_valid;
    test_reset_mid_frame;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
